program_loader: RTL

//  Write-side counterpart of the instruction ROM read by the core's PC.
//  - Receives a program as a byte stream over a valid/ready handshake.
//  - Writes it into an on-block instruction RAM, checks a checksum, then releases the core from reset.
//  - The core keeps reading instructions combinationally through pc_addr/instr.

---
 rtl/program_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: frames SYNC/COUNT/data/CHECKSUM into an instruction RAM
// and releases the core from reset once the checksum matches.
module program_loader #(
    parameter int INSTR_WIDTH = 8,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic [ADDR_WIDTH-1:0]   pc_addr,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic                    core_rst,
    output logic                    load_done,
    output logic                    load_err,
    output logic [ADDR_WIDTH:0]     words_loaded
);
    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [7:0]            SYNC    = 8'h5A;
    localparam logic [8:0]            DEPTH9  = 9'(DEPTH);
    localparam logic [BCW-1:0]        LAST_BC = BCW'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                  r_state, w_next;
    logic [INSTR_WIDTH-1:0]  r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0]  r_word;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]     r_words;
    logic [ADDR_WIDTH:0]     r_count;
    logic [BCW-1:0]          r_byte_cnt;
    logic [7:0]              r_sum;
    logic                    w_acc;
    logic                    w_count_ok;
    logic                    w_last_byte;
    logic [ADDR_WIDTH:0]     w_words_inc;
    logic [INSTR_WIDTH+7:0]  w_shift;

    assign w_acc       = in_valid && in_ready;
    assign w_count_ok  = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH9);
    assign w_last_byte = (r_byte_cnt == LAST_BC);
    assign w_words_inc = r_words + ONE_W;
    // Little-endian assembly: each new byte enters at the top and slides down.
    assign w_shift     = {in_data, r_word};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b1;
        core_rst  = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_acc && in_data == SYNC) w_next = S_COUNT;
            S_COUNT: if (w_acc) w_next = w_count_ok ? S_LOAD : S_ERROR;
            S_LOAD:  if (w_acc && w_last_byte) w_next = S_WRITE;
            S_WRITE: begin
                in_ready = 1'b0;
                w_next   = (w_words_inc < r_count) ? S_LOAD : S_CHECK;
            end
            S_CHECK: if (w_acc) w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
            S_DONE: begin
                core_rst  = 1'b0;
                load_done = 1'b1;
                if (w_acc && in_data == SYNC) w_next = S_COUNT;
            end
            S_ERROR: begin
                load_err = 1'b1;
                if (w_acc && in_data == SYNC) w_next = S_COUNT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_words    <= '0;
            r_count    <= '0;
            r_byte_cnt <= '0;
            r_sum      <= '0;
        end else begin
            case (r_state)
                S_COUNT: if (w_acc && w_count_ok) begin
                    r_count    <= in_data[ADDR_WIDTH:0];
                    r_words    <= '0;
                    r_sum      <= '0;
                    r_wr_ptr   <= '0;
                    r_byte_cnt <= '0;
                end
                S_LOAD: if (w_acc) begin
                    r_sum      <= r_sum + in_data;
                    r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
                end
                S_WRITE: begin
                    r_wr_ptr <= r_wr_ptr + ONE_A;
                    r_words  <= w_words_inc;
                end
                default: ;
            endcase
        end
    end

    // Word buffer and RAM are data-only: never reset, so a reset mid-load keeps written words.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && w_acc) r_word <= w_shift[INSTR_WIDTH+7:8];
        if (r_state == S_WRITE) r_mem[r_wr_ptr] <= r_word;
    end

    assign instr        = r_mem[pc_addr];
    assign words_loaded = r_words;
endmodule
